// File: rtl/wb_demux_regbank.sv
// wb_demux_regbank: buffered write demux into an 8x8 register bank (optional macro REGBANK_R0_ZERO_EN hardwires Reg0 to zero)
module wb_demux_regbank #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       WrValid,
    input  logic [2:0] WrSel,
    input  logic [7:0] WrData,
    output logic       WrReady,
    input  logic       Hold,
    output logic [7:0] Reg0,
    output logic [7:0] Reg1,
    output logic [7:0] Reg2,
    output logic [7:0] Reg3,
    output logic [7:0] Reg4,
    output logic [7:0] Reg5,
    output logic [7:0] Reg6,
    output logic [7:0] Reg7,
    output logic [7:0] WrEnOneHot,
    output logic [7:0] Pending
);
    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [10:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    reg_q [8];
    logic [7:0]    reg_d [8];
    logic [7:0]    wr_en_q, wr_en_d, dec;
    logic [10:0]   head;
    logic          push, pop;

    assign WrReady    = count_q < CW'(FIFO_DEPTH);
    assign WrEnOneHot = wr_en_q;
    assign Reg0 = reg_q[0];
    assign Reg1 = reg_q[1];
    assign Reg2 = reg_q[2];
    assign Reg3 = reg_q[3];
    assign Reg4 = reg_q[4];
    assign Reg5 = reg_q[5];
    assign Reg6 = reg_q[6];
    assign Reg7 = reg_q[7];

    // next-state: push/pop the FIFO and write the popped entry into its one-hot target
    always_comb begin
        push     = WrValid && WrReady;
        pop      = !Hold && count_q != '0;
        head     = mem_q[rd_ptr_q];
        dec      = pop ? (8'b1 << head[10:8]) : 8'h00;
`ifdef REGBANK_R0_ZERO_EN
        dec[0]   = 1'b0;
`endif
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {WrSel, WrData};
        reg_d    = reg_q;
        for (int i = 0; i < 8; i++)
            if (dec[i]) reg_d[i] = head[7:0];
        wr_en_d  = dec;
    end

    // pending mask: OR of decoded targets over entries between read pointer and occupancy
    always_comb begin
        Pending = 8'h00;
        off     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) Pending = Pending | (8'b1 << mem_q[i][10:8]);
        end
    end

    // FIFO storage needs no reset; occupancy gates every use of it
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    // control and bank state with synchronous active-low reset dominating everything
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_en_q  <= 8'h00;
            for (int i = 0; i < 8; i++) reg_q[i] <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_en_q  <= wr_en_d;
            reg_q    <= reg_d;
        end
    end
endmodule

// File: doc/wb_demux_regbank.md
WB_DEMUX_REGBANK -- requirements
Module: wb_demux_regbank

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 2, write-request buffer depth; legal values 2 or 4.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port WrValid, input, 1, write request present.
REQ-005 The block SHALL have port WrSel, input, 3, destination register index 0-7.
REQ-006 The block SHALL have port WrData, input, 8, data to write.
REQ-007 The block SHALL have port WrReady, output, 1, buffer can accept a request this cycle.
REQ-008 The block SHALL have port Hold, input, 1, pipeline stall; blocks draining of the buffer.
REQ-009 The block SHALL have ports Reg0..Reg7, output, 8 each, registered bank contents, one per index; these feed the 8:1 read-select inputs In0..In7.
REQ-010 The block SHALL have port WrEnOneHot, output, 8, registered one-hot of the register written on the last edge.
REQ-011 The block SHALL have port Pending, output, 8, bit i is set while any buffered request targets index i.

Function
REQ-012 A request SHALL be accepted on a rising edge where WrValid and WrReady are both 1; {WrSel, WrData} SHALL be pushed into an in-order FIFO.
REQ-013 WrReady SHALL be 1 when FIFO occupancy < FIFO_DEPTH and 0 when full; it SHALL depend only on registered occupancy, never on same-cycle pop.
REQ-014 On each edge with Hold=0 and FIFO non-empty, the head entry SHALL be popped and its data written into register Reg[WrSel] only, via 3-to-8 one-hot decode; all other registers hold.
REQ-015 Latency: a request accepted at edge N into an empty FIFO with Hold=0 SHALL appear on its Reg output after edge N+1.
REQ-016 Simultaneous push and pop SHALL be allowed; occupancy stays unchanged and order is preserved.
REQ-017 WrEnOneHot SHALL equal the decoded index of the entry popped on the last edge, and all-zero on edges with no pop; it is a one-cycle pulse per write.
REQ-018 Consecutive writes to the same index SHALL be applied in acceptance order; the last-accepted value SHALL remain.
REQ-019 Hold=1 SHALL freeze the FIFO head, the Reg outputs and WrEnOneHot (forced to 0); pushes continue until full.
REQ-020 Pending SHALL be recomputed combinationally from valid FIFO entries; Pending SHALL be 0 whenever occupancy is 0.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH without skipping or duplicating entries.

Reset
REQ-022 With Rst_n=0 at an edge, the block SHALL clear Reg0..Reg7 to 8'h00, WrEnOneHot to 0, occupancy and pointers to 0, WrReady to 1 after that edge; reset SHALL take priority over Hold, push and pop.
REQ-023 Requests buffered when reset asserts mid-operation SHALL be discarded, not written.

Configuration
REQ-024 With macro REGBANK_R0_ZERO_EN defined, Reg0 SHALL be constant 8'h00; index-0 requests SHALL be accepted and popped normally, but SHALL NOT change Reg0, and WrEnOneHot[0] SHALL never assert.
REQ-025 Without REGBANK_R0_ZERO_EN, index 0 SHALL behave as any other register.

Verification
REQ-026 After reset, single write WrSel=3, WrData=8'hA5, Hold=0 -> Reg3=8'hA5 after the next edge; WrEnOneHot=8'b0000_1000 for one cycle; other registers remain 8'h00.
REQ-027 With Hold=1, push 3 requests with FIFO_DEPTH=2 -> WrReady=0 after two accepts; the third request is held off; after Hold drops, the first two writes apply on successive edges, then the third is accepted.
REQ-028 Back-to-back writes to index 5 (8'h11, then 8'h22) with push/pop overlap -> Reg5=8'h11 then 8'h22; Pending[5]=1 while buffered.
REQ-029 Fill the FIFO and assert Rst_n=0 mid-drain -> all Reg outputs = 8'h00, Pending=0, WrReady=1; no buffered data appears.
REQ-030 With REGBANK_R0_ZERO_EN defined, write WrSel=0, WrData=8'hFF -> Reg0 stays 8'h00; WrEnOneHot=0; WrReady recovers.
REQ-031 Random 1000-request stream across pointer wrap with random Hold -> final Reg0..Reg7 match a reference model of in-order last-writer-wins.
